// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with valid/ready load
// handshake and a framing strobe (ser_valid/ser_last).
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to every
// frame (WIDTH+1 cycles per frame). Without it a frame is exactly WIDTH bits.
//
// state | meaning
// IDLE  | no frame in progress, ready for a word
// SHIFT | sending data bits, r_cnt = index of the bit on ser_out
// PAR   | sending the parity bit (PISO_PARITY_EN only)
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_ready, w_ready_nxt;
  logic             w_accept;
  logic             w_bit;
  logic [WIDTH-1:0] w_sr_shift;
`ifdef PISO_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  assign w_accept   = load_valid && r_ready;
  assign w_bit      = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
  assign w_sr_shift = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
  assign load_ready = r_ready;

  // Next-state, next-datapath and frame outputs; outputs decode from state so
  // an asynchronous clear forces them low without waiting for a clock edge.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
`ifdef PISO_PARITY_EN
    w_par_nxt   = r_par;
`endif
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    ser_last    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_sr_nxt    = load_data;
          w_cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
          w_par_nxt   = ^load_data;
`endif
        end
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = w_bit;
        if (r_cnt == LAST_IDX) begin
`ifdef PISO_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          ser_last = 1'b1;
          if (w_accept) begin
            w_sr_nxt  = load_data;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
`endif
        end else begin
          w_sr_nxt  = w_sr_shift;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
`ifdef PISO_PARITY_EN
      ST_PAR: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = r_par;
        ser_last  = 1'b1;
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_sr_nxt    = load_data;
          w_cnt_nxt   = '0;
          w_par_nxt   = ^load_data;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Ready is registered: high for the cycle the DUT will be idle or on the
  // final frame bit, so a word can be taken without a bubble.
  always_comb begin
    w_ready_nxt = (w_state_nxt == ST_IDLE);
`ifdef PISO_PARITY_EN
    if (w_state_nxt == ST_PAR) w_ready_nxt = 1'b1;
`else
    if ((w_state_nxt == ST_SHIFT) && (w_cnt_nxt == LAST_IDX)) w_ready_nxt = 1'b1;
`endif
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance,
// expected {bit,last} pairs queued at each accept and popped per frame cycle.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         clear_n;
  logic [W-1:0] ld_a, ld_b;
  logic         lv_a, lv_b;
  logic         rdy_a, out_a, val_a, last_a, busy_a;
  logic         rdy_b, out_b, val_b, last_b, busy_b;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .clear_n(clear_n), .load_data(ld_a), .load_valid(lv_a),
    .load_ready(rdy_a), .ser_out(out_a), .ser_valid(val_a), .ser_last(last_a), .busy(busy_a));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .clear_n(clear_n), .load_data(ld_b), .load_valid(lv_b),
    .load_ready(rdy_b), .ser_out(out_b), .ser_valid(val_b), .ser_last(last_b), .busy(busy_b));

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic       exp_rdy_a, exp_rdy_b;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input bit a, input logic [W-1:0] d, input bit msb);
    logic [1:0] e;
    for (int i = 0; i < W; i++) begin
      e[1] = msb ? d[W-1-i] : d[i];
      e[0] = (i == W - 1) && !PAR_EN;
      if (a) q_a.push_back(e); else q_b.push_back(e);
    end
    if (PAR_EN) begin
      e = {^d, 1'b1};
      if (a) q_a.push_back(e); else q_b.push_back(e);
    end
  endtask

  task automatic chk_dut(input string nm, input bit a,
                         input logic v, input logic o, input logic l, input logic b, input logic r);
    logic [1:0] e;
    bit         have;
    logic       er;
    if (!clear_n) begin
      check({nm, ".rst_valid"}, v, 1'b0);
      check({nm, ".rst_out"},   o, 1'b0);
      check({nm, ".rst_last"},  l, 1'b0);
      check({nm, ".rst_busy"},  b, 1'b0);
      check({nm, ".rst_ready"}, r, 1'b0);
      if (a) exp_rdy_a = 1'b0; else exp_rdy_b = 1'b0;
      return;
    end
    have = a ? (q_a.size() > 0) : (q_b.size() > 0);
    e = 2'b00;
    if (have) e = a ? q_a.pop_front() : q_b.pop_front();
    er = have ? e[0] : 1'b1;
    check({nm, ".valid"}, v, have);
    check({nm, ".busy"},  b, have);
    check({nm, ".out"},   o, e[1]);
    check({nm, ".last"},  l, e[0]);
    check({nm, ".ready"}, r, er);
    if (a) exp_rdy_a = er; else exp_rdy_b = er;
  endtask

  task automatic cyc();
    bit acc_a, acc_b;
    acc_a = lv_a && exp_rdy_a;
    acc_b = lv_b && exp_rdy_b;
    @(posedge clock);
    if (acc_a) push_frame(1'b1, ld_a, 1'b1);
    if (acc_b) push_frame(1'b0, ld_b, 1'b0);
    @(negedge clock);
    chk_dut("msb", 1'b1, val_a, out_a, last_a, busy_a, rdy_a);
    chk_dut("lsb", 1'b0, val_b, out_b, last_b, busy_b, rdy_b);
  endtask

  task automatic send(input bit a, input logic [W-1:0] d);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    if (a) begin lv_a = 1'b1; ld_a = d; end
    else   begin lv_b = 1'b1; ld_b = d; end
    while (!acc && n < 40) begin
      acc = a ? exp_rdy_a : exp_rdy_b;
      cyc();
      n++;
    end
    check("send_accept", acc, 1'b1);
    if (a) begin lv_a = 1'b0; ld_a = W'($urandom); end
    else   begin lv_b = 1'b0; ld_b = W'($urandom); end
  endtask

  initial begin
    clear_n = 1'b1;
    lv_a = 1'b0; lv_b = 1'b0;
    ld_a = '0;   ld_b = '0;
    exp_rdy_a = 1'b0; exp_rdy_b = 1'b0;
    #2 clear_n = 1'b0;

    // reset held for 3 cycles, then release
    repeat (3) cyc();
    clear_n = 1'b1;
    repeat (2) cyc();

    // single frame MSB first
    send(1'b1, 8'hA5);
    repeat (10) cyc();

    // LSB-first instance
    send(1'b0, 8'h01);
    repeat (10) cyc();

    // back-to-back: second word held valid until ready on the last bit
    send(1'b1, 8'hFF);
    send(1'b1, 8'h00);
    repeat (10) cyc();

    // both instances busy together
    send(1'b0, 8'h96);
    send(1'b1, 8'h3C);
    repeat (12) cyc();

    // asynchronous clear during the third bit of 8'hC3
    send(1'b1, 8'hC3);
    cyc();
    cyc();
    #2 clear_n = 1'b0;
    #1;
    chk_dut("msb_async", 1'b1, val_a, out_a, last_a, busy_a, rdy_a);
    chk_dut("lsb_async", 1'b0, val_b, out_b, last_b, busy_b, rdy_b);
    q_a.delete();
    q_b.delete();
    @(negedge clock);
    repeat (2) cyc();
    clear_n = 1'b1;
    repeat (3) cyc();
    send(1'b1, 8'h5A);
    repeat (10) cyc();

    // parity-relevant words, back-to-back
    send(1'b1, 8'h07);
    send(1'b1, 8'h03);
    repeat (12) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
